// File: rtl/sha_msg_mem.sv
// SHA message/hash word store: engine port with priority, host load stream, paced dump readout.
// Optional SHA_MSG_MEM_RANGE_CHECK_EN: out-of-range accesses are dropped/zeroed and flagged on err.
module sha_msg_mem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        engine_busy,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        dump_start,
  input  logic [15:0] dump_addr,
  input  logic [7:0]  dump_count,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic        dump_done,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, FIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [15:0] d_addr;
  logic [7:0]  d_rem;
  logic        run;
  logic        load_fire;
  logic        start_ok;
  logic        fetch_en;
  logic        eng_ok, load_ok, dump_ok;

  `ifdef SHA_MSG_MEM_RANGE_CHECK_EN
  assign eng_ok  = 32'(mem_addr)  < DEPTH;
  assign load_ok = 32'(load_addr) < DEPTH;
  assign dump_ok = 32'(d_addr)    < DEPTH;

  // An idle engine's address lines are not an access; only busy or writing cycles count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (((mem_we || engine_busy) && !eng_ok) ||
                 (load_fire && !load_ok) || (fetch_en && !dump_ok)) begin
      err <= 1'b1;
    end
  end
  `else
  logic unused_hi_addr_bits;
  assign eng_ok  = 1'b1;
  assign load_ok = 1'b1;
  assign dump_ok = 1'b1;
  assign err     = 1'b0;
  assign unused_hi_addr_bits = ^{mem_addr[15:AW], load_addr[15:AW]};
  `endif

  // mem_we gates load_ready so a host word is never silently lost to an engine write.
  assign load_ready = run && (state == IDLE) && !engine_busy && !mem_we;
  assign load_fire  = load_valid && load_ready;
  assign start_ok   = dump_start && !engine_busy && !load_valid;
  assign dump_valid = (state == SEND);
  assign dump_done  = (state == FIN);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (eng_ok) mem[mem_addr[AW-1:0]] <= mem_wdata;
    end else if (load_fire && load_ok) begin
      mem[load_addr[AW-1:0]] <= load_data;
    end
  end

  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    unique case (state)
      IDLE:  if (start_ok) state_nxt = (dump_count == 8'd0) ? FIN : FETCH;
      FETCH: if (!engine_busy) begin
               fetch_en  = 1'b1;
               state_nxt = SEND;
             end
      SEND:  if (dump_ready) state_nxt = (d_rem == 8'd1) ? FIN : FETCH;
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      run       <= 1'b0;
      mem_rdata <= '0;
      dump_data <= '0;
      d_addr    <= '0;
      d_rem     <= '0;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      mem_rdata <= eng_ok ? mem[mem_addr[AW-1:0]] : '0;
      if (fetch_en) dump_data <= dump_ok ? mem[d_addr[AW-1:0]] : '0;
      if (state == IDLE && start_ok) begin
        d_addr <= dump_addr;
        d_rem  <= dump_count;
      end else if (state == SEND && dump_ready) begin
        d_addr <= d_addr + 16'd1;
        d_rem  <= d_rem - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_mem.sv
// Self-checking bench for sha_msg_mem (DEPTH=256) against an array-based reference model.
module tb_sha_msg_mem;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        engine_busy = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic        dump_start = 1'b0;
  logic [15:0] dump_addr = '0;
  logic [7:0]  dump_count = '0;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  sha_msg_mem #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .engine_busy(engine_busy),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
    .dump_start(dump_start), .dump_addr(dump_addr), .dump_count(dump_count),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data), .dump_done(dump_done),
    .err(err)
  );

  function automatic int unsigned widx(input logic [15:0] a);
    return int'(a) % DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [15:0] a, input logic [7:0] n);
    dump_addr  = a;
    dump_count = n;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 6;
    if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", mem_rdata); end
    if (load_ready !== 1'b0) begin errors++; $display("FAIL reset_load_ready got=%b exp=0", load_ready); end
    if (dump_valid !== 1'b0) begin errors++; $display("FAIL reset_dump_valid got=%b exp=0", dump_valid); end
    if (dump_data !== 32'h0) begin errors++; $display("FAIL reset_dump_data got=%h exp=0", dump_data); end
    if (dump_done !== 1'b0) begin errors++; $display("FAIL reset_dump_done got=%b exp=0", dump_done); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (load_ready !== 1'b1) begin errors++; $display("FAIL post_reset_load_ready got=%b exp=1", load_ready); end
  endtask

  // Fills the whole array so every later expectation is defined; 0x10..0x1F get 0..F.
  task automatic test_load_fill();
    for (int a = 0; a < int'(DEPTH); a++) begin
      load_valid = 1'b1;
      load_addr  = 16'(a);
      load_data  = (a >= 16 && a < 32) ? 32'(a - 16) : $urandom;
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready addr=%0d got=%b exp=1", a, load_ready); end
      tick();
      ref_mem[a] = load_data;
    end
    load_valid = 1'b0;
  endtask

  task automatic test_engine_read();
    logic [15:0] q[$];
    for (int i = 16; i < 32; i++) q.push_back(16'(i));
    for (int i = 0; i < 20; i++) q.push_back(16'($urandom_range(0, DEPTH - 1)));
    mem_addr = q[0];
    tick();
    for (int i = 1; i <= q.size(); i++) begin
      checks++;
      if (mem_rdata !== ref_mem[widx(q[i-1])])
        begin errors++; $display("FAIL engine_read addr=%h got=%h exp=%h", q[i-1], mem_rdata, ref_mem[widx(q[i-1])]); end
      if (i < q.size()) mem_addr = q[i];
      tick();
    end
  endtask

  task automatic test_engine_write();
    logic [15:0] a;
    logic [31:0] w, old;
    for (int i = 0; i < 8; i++) begin
      a = (i == 0) ? 16'h0080 : 16'($urandom_range(0, DEPTH - 1));
      w = (i == 0) ? 32'h6A09E667 : $urandom;
      old = ref_mem[widx(a)];
      mem_addr = a; mem_wdata = w; mem_we = 1'b1;
      tick();
      mem_we = 1'b0;
      ref_mem[widx(a)] = w;
      checks++;
      if (mem_rdata !== old) begin errors++; $display("FAIL write_old addr=%h got=%h exp=%h", a, mem_rdata, old); end
      tick();
      checks++;
      if (mem_rdata !== w) begin errors++; $display("FAIL write_new addr=%h got=%h exp=%h", a, mem_rdata, w); end
    end
  endtask

  task automatic test_dump_stall();
    int beats = 0, dones = 0;
    logic stall = 1'b0;
    logic [31:0] held = '0, exp;
    start_dump(16'h0080, 8'd8);
    for (int cyc = 0; cyc < 100 && dones == 0; cyc++) begin
      dump_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (dump_valid) begin
        if (stall) begin
          checks++;
          if (dump_data !== held) begin errors++; $display("FAIL dump_stable got=%h exp=%h", dump_data, held); end
        end
        if (dump_ready) begin
          exp = ref_mem[widx(16'h0080 + 16'(beats))];
          checks++;
          if (dump_data !== exp) begin errors++; $display("FAIL dump_beat%0d got=%h exp=%h", beats, dump_data, exp); end
          beats++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held = dump_data;
        end
      end
      if (dump_done) dones++;
      tick();
    end
    dump_ready = 1'b0;
    checks += 3;
    if (beats != 8) begin errors++; $display("FAIL dump_beats got=%0d exp=8", beats); end
    if (dones != 1) begin errors++; $display("FAIL dump_done_seen got=%0d exp=1", dones); end
    @(negedge clk);
    if (dump_done !== 1'b0) begin errors++; $display("FAIL dump_done_width got=%b exp=0", dump_done); end
  endtask

  task automatic test_dump_throughput();
    logic [15:0] a;
    int beats = 0, dones = 0, last = 0;
    logic [31:0] exp;
    `ifdef SHA_MSG_MEM_RANGE_CHECK_EN
    a = 16'h00F0;
    `else
    a = 16'hFFFE;
    `endif
    start_dump(a, 8'd6);
    dump_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && dones == 0; cyc++) begin
      @(negedge clk);
      if (dump_valid) begin
        exp = ref_mem[widx(a + 16'(beats))];
        checks++;
        if (dump_data !== exp) begin errors++; $display("FAIL tput_beat%0d got=%h exp=%h", beats, dump_data, exp); end
        if (beats > 0) begin
          checks++;
          if (cyc - last != 2) begin errors++; $display("FAIL tput_spacing got=%0d exp=2", cyc - last); end
        end
        last = cyc;
        beats++;
      end
      if (dump_done) dones++;
      tick();
    end
    dump_ready = 1'b0;
    checks++;
    if (beats != 6 || dones != 1) begin errors++; $display("FAIL tput_count beats=%0d dones=%0d exp=6/1", beats, dones); end
  endtask

  task automatic test_busy_middump();
    logic [15:0] a;
    int beats = 0, dones = 0, busy_left = 0;
    logic go_busy = 1'b0;
    logic [31:0] exp;
    a = 16'($urandom_range(0, 200));
    start_dump(a, 8'd4);
    dump_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && dones == 0; cyc++) begin
      @(negedge clk);
      if (engine_busy) begin
        checks++;
        if (dump_valid !== 1'b0) begin errors++; $display("FAIL busy_hold got=%b exp=0", dump_valid); end
      end else if (dump_valid) begin
        exp = ref_mem[widx(a + 16'(beats))];
        checks++;
        if (dump_data !== exp) begin errors++; $display("FAIL busy_beat%0d got=%h exp=%h", beats, dump_data, exp); end
        beats++;
        if (beats == 2) go_busy = 1'b1;
      end
      if (dump_done) dones++;
      tick();
      mem_we = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) engine_busy = 1'b0;
      end
      if (go_busy) begin
        go_busy = 1'b0;
        engine_busy = 1'b1;
        busy_left = 6;
        mem_we = 1'b1;
        mem_addr = a + 16'd2;
        mem_wdata = $urandom;
        ref_mem[widx(a + 16'd2)] = mem_wdata;
      end
    end
    dump_ready = 1'b0;
    engine_busy = 1'b0;
    checks++;
    if (beats != 4 || dones != 1) begin errors++; $display("FAIL busy_count beats=%0d dones=%0d exp=4/1", beats, dones); end
  endtask

  task automatic test_busy_block();
    engine_busy = 1'b1;
    load_valid = 1'b1;
    load_addr = 16'h0033;
    load_data = ~ref_mem[8'h33];
    dump_addr = 16'h0000;
    dump_count = 8'd4;
    dump_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0)
        begin errors++; $display("FAIL busy_block ready=%b valid=%b done=%b exp=0/0/0", load_ready, dump_valid, dump_done); end
      tick();
    end
    engine_busy = 1'b0;
    load_valid = 1'b0;
    dump_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dump_valid !== 1'b0 || dump_done !== 1'b0)
        begin errors++; $display("FAIL no_queue valid=%b done=%b exp=0/0", dump_valid, dump_done); end
      tick();
    end
    mem_addr = 16'h0033;
    tick();
    checks++;
    if (mem_rdata !== ref_mem[8'h33]) begin errors++; $display("FAIL busy_nowrite got=%h exp=%h", mem_rdata, ref_mem[8'h33]); end
    start_dump(16'h0010, 8'd0);
    checks++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0)
      begin errors++; $display("FAIL count0 done=%b valid=%b exp=1/0", dump_done, dump_valid); end
    tick();
    checks++;
    if (dump_done !== 1'b0 || dump_valid !== 1'b0)
      begin errors++; $display("FAIL count0_after done=%b valid=%b exp=0/0", dump_done, dump_valid); end
  endtask

  task automatic test_range();
    logic [31:0] w, old0, exp_rd, exp_new;
    logic exp_err;
    w = $urandom;
    old0 = ref_mem[0];
    `ifdef SHA_MSG_MEM_RANGE_CHECK_EN
    exp_rd = 32'h0; exp_new = old0; exp_err = 1'b1;
    `else
    exp_rd = old0; exp_new = w; exp_err = 1'b0;
    `endif
    mem_addr = 16'h0100; mem_wdata = w; mem_we = 1'b1;
    tick();
    mem_we = 1'b0;
    ref_mem[0] = exp_new;
    checks++;
    if (mem_rdata !== exp_rd) begin errors++; $display("FAIL range_rd got=%h exp=%h", mem_rdata, exp_rd); end
    mem_addr = 16'h0000;
    tick();
    checks += 2;
    if (mem_rdata !== exp_new) begin errors++; $display("FAIL range_addr0 got=%h exp=%h", mem_rdata, exp_new); end
    if (err !== exp_err) begin errors++; $display("FAIL range_err got=%b exp=%b", err, exp_err); end
  endtask

  task automatic test_reset_middump();
    logic [15:0] a;
    int beats = 0;
    logic hit = 1'b0;
    a = 16'($urandom_range(0, 200));
    start_dump(a, 8'd8);
    dump_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      @(negedge clk);
      if (dump_valid) begin
        if (beats == 2) hit = 1'b1;
        else beats++;
      end
      if (!hit) tick();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_dump_reach beats=%0d exp=2", beats); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_data !== 32'h0)
      begin errors++; $display("FAIL rst_abort valid=%b done=%b data=%h exp=0/0/0", dump_valid, dump_done, dump_data); end
    dump_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dump_done !== 1'b0) begin errors++; $display("FAIL rst_hold_done got=%b exp=0", dump_done); end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0)
        begin errors++; $display("FAIL rst_after done=%b valid=%b exp=0/0", dump_done, dump_valid); end
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
    mem_addr = a;
    tick();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (mem_rdata !== ref_mem[widx(a + 16'(i - 1))])
        begin errors++; $display("FAIL rst_keep addr=%h got=%h exp=%h", a + 16'(i - 1), mem_rdata, ref_mem[widx(a + 16'(i - 1))]); end
      mem_addr = a + 16'(i);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    for (int i = 0; i < 32; i++) begin
      load_valid = 1'b1;
      load_addr = 16'($urandom_range(0, DEPTH - 1));
      load_data = $urandom;
      q.push_back(load_addr);
      @(negedge clk);
      checks++;
      if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready idx=%0d got=%b exp=1", i, load_ready); end
      tick();
      ref_mem[widx(load_addr)] = load_data;
    end
    load_valid = 1'b0;
    mem_addr = q[0];
    tick();
    for (int i = 1; i <= q.size(); i++) begin
      checks++;
      if (mem_rdata !== ref_mem[widx(q[i-1])])
        begin errors++; $display("FAIL b2b_read addr=%h got=%h exp=%h", q[i-1], mem_rdata, ref_mem[widx(q[i-1])]); end
      if (i < q.size()) mem_addr = q[i];
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_fill();
    test_engine_read();
    test_engine_write();
    test_dump_stall();
    test_dump_throughput();
    test_busy_middump();
    test_busy_block();
    test_back_to_back();
    test_range();
    test_reset_middump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_msg_mem.md
SHA_MSG_MEM -- requirements
Module: sha_msg_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 256, number of 32-bit words stored; power of two, 16 to 4096.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port mem_we, input, 1, engine write enable.
REQ-005 SHALL have port mem_addr, input, 16, engine word address.
REQ-006 SHALL have port mem_wdata, input, 32, engine write data.
REQ-007 SHALL have port mem_rdata, output, 32, engine read data.
REQ-008 SHALL have port engine_busy, input, 1, engine owns the array (start to done).
REQ-009 SHALL have ports load_valid/load_ready (in/out, 1), load_addr (in, 16), load_data (in, 32); host word-load stream.
REQ-010 SHALL have ports dump_start (in, 1), dump_addr (in, 16), dump_count (in, 8); host hash-readout request.
REQ-011 SHALL have ports dump_valid (out, 1), dump_ready (in, 1), dump_data (out, 32), dump_done (out, 1); readout stream.
REQ-012 SHALL have port err, output, 1, sticky address-range error.

Function
REQ-013 SHALL store DEPTH x 32-bit words, written synchronously.
REQ-014 Engine read: mem_rdata SHALL equal array[mem_addr] sampled at edge N, visible after edge N (one-cycle latency), every cycle with mem_we=0.
REQ-015 Engine write: mem_we=1 at edge N SHALL write mem_wdata; mem_rdata after that edge SHALL return old contents (read-before-write).
REQ-016 load_ready SHALL be 1 only when engine_busy=0 and dump FSM is IDLE; a word is written when load_valid&&load_ready at an edge.
REQ-017 Engine port SHALL always have priority; host load/dump never stalls the engine.
REQ-018 Dump FSM states: IDLE, FETCH, SEND, FIN.
REQ-019 IDLE -> FETCH on dump_start=1 with engine_busy=0 and load_valid=0; latch dump_addr/dump_count; dump_start otherwise ignored (no queueing).
REQ-020 dump_count=0: IDLE -> FIN directly, no dump_valid beat.
REQ-021 FETCH: issue read of current address; -> SEND next cycle with dump_valid=1.
REQ-022 SEND: dump_data SHALL be held stable while dump_valid && !dump_ready; on handshake increment address, decrement remaining; remaining 0 -> FIN, else -> FETCH.
REQ-023 FIN: dump_done=1 for exactly one cycle, then IDLE.
REQ-024 engine_busy rising mid-dump: FSM SHALL finish current beat, then hold in FETCH until engine_busy=0 (no array read meanwhile).
REQ-025 Throughput: one dump beat per two cycles with dump_ready held high; one load word per cycle.
REQ-026 Address arithmetic 16-bit; dump address increments past 16'hFFFF wrap to 0.

Reset
REQ-027 On rst_n=0: mem_rdata=0, load_ready=0, dump_valid=0, dump_data=0, dump_done=0, err=0, FSM IDLE; array contents not reset.
REQ-028 Reset asserted mid-dump SHALL abort with no dump_done pulse; array unchanged.

Configuration
REQ-029 Macro SHA_MSG_MEM_RANGE_CHECK_EN defined: any access with address >= DEPTH SHALL drop writes, return 0 on reads, set err (sticky until reset).
REQ-030 Macro undefined: address SHALL be taken modulo DEPTH (low log2(DEPTH) bits); err tied 0.

Verification
REQ-031 Load 16 words 0x00000000..0x0000000F at addr 0x10..0x1F, then engine reads 0x10..0x1F -> mem_rdata 0x0..0xF, each one cycle after address.
REQ-032 Engine writes 0x6A09E667 to addr 0x80 at edge N with mem_addr held -> old value after N, 0x6A09E667 after N+1.
REQ-033 dump_addr=0x80, dump_count=8, dump_ready toggling 1/0 -> 8 beats in order, data stable during stalls, single dump_done pulse.
REQ-034 engine_busy=1 with load_valid=1 -> load_ready=0, no write; dump_start ignored; dump_count=0 -> dump_done next FSM step, no beat.
REQ-035 With SHA_MSG_MEM_RANGE_CHECK_EN, DEPTH=256: engine write to 0x0100 -> err=1, addr 0x00 unchanged; without macro -> addr 0x00 overwritten, err=0.
REQ-036 rst_n pulsed low mid-dump beat 3 -> dump_valid=0 immediately, no dump_done, previously loaded data still readable.
